// File: rtl/hvgen_param.sv
`default_nettype none
// ============================================================================
// Module   : hvgen_param
// Purpose  : Parametrised arcade video timing generator with jumped HPOS/VPOS,
//            frame-latched sync offsets, line/frame strobes and blanked RGB.
// Revision : 1.0  initial release
// ============================================================================
module hvgen_param #(
    parameter int W       = 9,
    parameter int CW      = 12,
    parameter int HACT    = 288,
    parameter int HS_S    = 311,
    parameter int HS_E    = 342,
    parameter int HJ_FROM = 342,
    parameter int HJ_TO   = 471,
    parameter int HMAX    = 511,
    parameter int VACT    = 223,
    parameter int VS_S    = 226,
    parameter int VS_E    = 233,
    parameter int VJ_FROM = 233,
    parameter int VJ_TO   = 483,
    parameter int VMAX    = 511
) (
    input  logic          PCLK,
    input  logic          RESET,
    input  logic          CE,
    input  logic [3:0]    HOFS,
    input  logic [3:0]    VOFS,
    input  logic [CW-1:0] iRGB,
    output logic [W-1:0]  HPOS,
    output logic [W-1:0]  VPOS,
    output logic [CW-1:0] oRGB,
    output logic          HBLK,
    output logic          VBLK,
    output logic          HSYN,
    output logic          VSYN,
    output logic          DE,
    output logic          LINE,
    output logic          FRAME
);

    localparam int c_HTOTAL = (HJ_FROM + 1) + (HMAX - HJ_TO + 1);
    localparam int c_VTOTAL = (VJ_FROM + 1) + (VMAX - VJ_TO + 1);
    localparam int c_XW     = W + 1;

    localparam logic [W-1:0] c_HLAST   = W'(c_HTOTAL - 1);
    localparam logic [W-1:0] c_VLAST   = W'(c_VTOTAL - 1);
    localparam logic [W-1:0] c_HACT    = W'(HACT);
    localparam logic [W-1:0] c_VACT    = W'(VACT);
    localparam logic [W-1:0] c_HJ_FROM = W'(HJ_FROM);
    localparam logic [W-1:0] c_VJ_FROM = W'(VJ_FROM);
    localparam logic [W-1:0] c_HJUMP   = W'(HJ_TO - HJ_FROM - 1);
    localparam logic [W-1:0] c_VJUMP   = W'(VJ_TO - VJ_FROM - 1);

    localparam logic signed [c_XW-1:0] c_HS_S = c_XW'(HS_S);
    localparam logic signed [c_XW-1:0] c_HS_E = c_XW'(HS_E);
    localparam logic signed [c_XW-1:0] c_VS_S = c_XW'(VS_S);
    localparam logic signed [c_XW-1:0] c_VS_E = c_XW'(VS_E);

    // Sync pulse must stay inside blanking for every offset in -8..+7.
    generate
        if (!((HACT < HS_S - 8) && (HS_E + 7 < c_HTOTAL - 1))) begin : g_bad_h_timing
            $error("hvgen_param: illegal horizontal timing parameters");
        end
        if (!((VACT < VS_S - 8) && (VS_E + 7 < c_VTOTAL - 1))) begin : g_bad_v_timing
            $error("hvgen_param: illegal vertical timing parameters");
        end
    endgenerate

    logic [W-1:0]          r_h;
    logic [W-1:0]          r_v;
    logic signed [3:0]     r_hofs;
    logic signed [3:0]     r_vofs;
    logic                  r_hblk;
    logic                  r_vblk;
    logic                  r_hsyn;
    logic                  r_vsyn;
    logic                  r_line;
    logic                  r_frame;
    logic [CW-1:0]         r_rgb;

    logic                  w_hlast;
    logic                  w_vlast;
    logic signed [c_XW-1:0] w_hofs_x;
    logic signed [c_XW-1:0] w_vofs_x;
    logic signed [c_XW-1:0] w_hs_s;
    logic signed [c_XW-1:0] w_hs_e;
    logic signed [c_XW-1:0] w_vs_s;
    logic signed [c_XW-1:0] w_vs_e;
    logic signed [c_XW-1:0] w_h_x;
    logic signed [c_XW-1:0] w_v_x;

    assign w_hlast  = (r_h == c_HLAST);
    assign w_vlast  = (r_v == c_VLAST);
    assign w_hofs_x = {{(c_XW - 4){r_hofs[3]}}, r_hofs};
    assign w_vofs_x = {{(c_XW - 4){r_vofs[3]}}, r_vofs};
    assign w_hs_s   = c_HS_S + w_hofs_x;
    assign w_hs_e   = c_HS_E + w_hofs_x;
    assign w_vs_s   = c_VS_S + w_vofs_x;
    assign w_vs_e   = c_VS_E + w_vofs_x;
    assign w_h_x    = {1'b0, r_h};
    assign w_v_x    = {1'b0, r_v};

    always_ff @(posedge PCLK or posedge RESET) begin
        if (RESET) begin
            r_h     <= '0;
            r_v     <= '0;
            r_hofs  <= '0;
            r_vofs  <= '0;
            r_hblk  <= 1'b1;
            r_vblk  <= 1'b1;
            r_hsyn  <= 1'b1;
            r_vsyn  <= 1'b1;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            r_rgb   <= '0;
        end else if (CE) begin
            r_h     <= w_hlast ? '0 : r_h + 1'b1;
            r_line  <= w_hlast;
            r_frame <= w_hlast && w_vlast;

            if (r_h == c_HACT) r_hblk <= 1'b1;
            if (w_hlast)       r_hblk <= 1'b0;
            if (w_h_x == w_hs_s) r_hsyn <= 1'b0;
            if (w_h_x == w_hs_e) r_hsyn <= 1'b1;

            if (w_hlast) begin
                r_v <= w_vlast ? '0 : r_v + 1'b1;
                if (r_v == c_VACT)   r_vblk <= 1'b1;
                if (w_v_x == w_vs_s) r_vsyn <= 1'b0;
                if (w_v_x == w_vs_e) r_vsyn <= 1'b1;
                if (w_vlast) begin
                    r_vblk <= 1'b0;
                    // New offsets only take effect from a frame boundary.
                    r_hofs <= HOFS;
                    r_vofs <= VOFS;
                end
            end

            r_rgb <= (r_hblk | r_vblk) ? '0 : iRGB;
        end
    end

    assign HPOS  = (r_h <= c_HJ_FROM) ? r_h : r_h + c_HJUMP;
    assign VPOS  = (r_v <= c_VJ_FROM) ? r_v : r_v + c_VJUMP;
    assign oRGB  = r_rgb;
    assign HBLK  = r_hblk;
    assign VBLK  = r_vblk;
    assign HSYN  = r_hsyn;
    assign VSYN  = r_vsyn;
    assign DE    = ~(r_hblk | r_vblk);
    assign LINE  = r_line;
    assign FRAME = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_hvgen_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_hvgen_param
// Purpose  : Directed self-checking bench for hvgen_param (short-frame config).
// Revision : 1.0  initial release
// ============================================================================
module tb_hvgen_param;

    // Horizontal timing is the default; vertical is shortened to 32 lines so
    // several frames fit in a short run.
    localparam int c_HT = 384;
    localparam int c_VT = 32;
    localparam int c_FT = c_HT * c_VT;

    logic        PCLK = 1'b0;
    logic        RESET;
    logic        CE;
    logic [3:0]  HOFS;
    logic [3:0]  VOFS;
    logic [11:0] iRGB;
    logic [8:0]  HPOS;
    logic [8:0]  VPOS;
    logic [11:0] oRGB;
    logic        HBLK;
    logic        VBLK;
    logic        HSYN;
    logic        VSYN;
    logic        DE;
    logic        LINE;
    logic        FRAME;

    int checks = 0;
    int errors = 0;
    int t      = 0;

    always #5 PCLK = ~PCLK;

    hvgen_param #(
        .W(9), .CW(12),
        .HACT(288), .HS_S(311), .HS_E(342), .HJ_FROM(342), .HJ_TO(471), .HMAX(511),
        .VACT(10), .VS_S(19), .VS_E(22), .VJ_FROM(22), .VJ_TO(503), .VMAX(511)
    ) dut (
        .PCLK(PCLK), .RESET(RESET), .CE(CE), .HOFS(HOFS), .VOFS(VOFS), .iRGB(iRGB),
        .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK),
        .HSYN(HSYN), .VSYN(VSYN), .DE(DE), .LINE(LINE), .FRAME(FRAME)
    );

    // Closed-form expectations as a function of CE edges since reset.
    function automatic int f_h(input int tt);  return tt % c_HT; endfunction
    function automatic int f_v(input int tt);  return (tt / c_HT) % c_VT; endfunction
    function automatic int f_fr(input int tt); return tt / c_FT; endfunction

    function automatic logic [8:0] f_hpos(input int tt);
        int h = f_h(tt);
        return 9'((h <= 342) ? h : h + 128);
    endfunction
    function automatic logic [8:0] f_vpos(input int tt);
        int v = f_v(tt);
        return 9'((v <= 22) ? v : v + 480);
    endfunction
    function automatic logic f_hblk(input int tt);
        return (tt / c_HT == 0) || (f_h(tt) >= 289);
    endfunction
    function automatic logic f_vblk(input int tt);
        return (f_fr(tt) == 0) || (f_v(tt) >= 11);
    endfunction
    function automatic logic f_de(input int tt);
        return !(f_hblk(tt) || f_vblk(tt));
    endfunction
    function automatic logic f_hsyn(input int tt, input int ho);
        int h = f_h(tt);
        return !((h >= 312 + ho) && (h <= 342 + ho));
    endfunction
    function automatic logic f_vsyn(input int tt, input int vo);
        int v = f_v(tt);
        return !((v >= 20 + vo) && (v <= 22 + vo));
    endfunction
    function automatic logic f_line(input int tt);
        return (tt > 0) && (f_h(tt) == 0);
    endfunction
    function automatic logic f_frame(input int tt);
        return (tt > 0) && (tt % c_FT == 0);
    endfunction

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; CE = 1'b1; HOFS = 4'd0; VOFS = 4'd0; iRGB = 12'hABC;
        repeat (3) tick();
        checks++; if (HPOS !== 9'd0)   begin errors++; $display("FAIL rst_hpos got %0d exp 0", HPOS); end
        checks++; if (VPOS !== 9'd0)   begin errors++; $display("FAIL rst_vpos got %0d exp 0", VPOS); end
        checks++; if (HBLK !== 1'b1)   begin errors++; $display("FAIL rst_hblk got %b exp 1", HBLK); end
        checks++; if (VBLK !== 1'b1)   begin errors++; $display("FAIL rst_vblk got %b exp 1", VBLK); end
        checks++; if (HSYN !== 1'b1)   begin errors++; $display("FAIL rst_hsyn got %b exp 1", HSYN); end
        checks++; if (VSYN !== 1'b1)   begin errors++; $display("FAIL rst_vsyn got %b exp 1", VSYN); end
        checks++; if (oRGB !== 12'h0)  begin errors++; $display("FAIL rst_orgb got %h exp 0", oRGB); end
        checks++; if (LINE !== 1'b0)   begin errors++; $display("FAIL rst_line got %b exp 0", LINE); end
        checks++; if (FRAME !== 1'b0)  begin errors++; $display("FAIL rst_frame got %b exp 0", FRAME); end
        checks++; if (DE !== 1'b0)     begin errors++; $display("FAIL rst_de got %b exp 0", DE); end
        RESET = 1'b0;
        t = 0;
    endtask

    task automatic test_hline();
        int line_cnt = 0;
        int hsyn_low = 0;
        for (int i = 0; i < 2 * c_HT; i++) begin
            tick(); t++;
            if (LINE === 1'b1) line_cnt++;
            if (HSYN === 1'b0) hsyn_low++;
            checks++; if (HPOS !== f_hpos(t)) begin errors++; $display("FAIL hl_hpos t=%0d got %0d exp %0d", t, HPOS, f_hpos(t)); end
            checks++; if (HBLK !== f_hblk(t)) begin errors++; $display("FAIL hl_hblk t=%0d got %b exp %b", t, HBLK, f_hblk(t)); end
            checks++; if (LINE !== f_line(t)) begin errors++; $display("FAIL hl_line t=%0d got %b exp %b", t, LINE, f_line(t)); end
            checks++; if (HSYN !== f_hsyn(t, 0)) begin errors++; $display("FAIL hl_hsyn t=%0d got %b exp %b", t, HSYN, f_hsyn(t, 0)); end
        end
        checks++; if (line_cnt != 2)  begin errors++; $display("FAIL hl_line_count got %0d exp 2", line_cnt); end
        checks++; if (hsyn_low != 62) begin errors++; $display("FAIL hl_hsyn_width got %0d exp 62", hsyn_low); end
    endtask

    task automatic test_frame();
        int frame_cnt = 0;
        int vsyn_low  = 0;
        while (t < c_FT + 16 * c_HT) begin
            tick(); t++;
            if (FRAME === 1'b1) frame_cnt++;
            if (VSYN === 1'b0)  vsyn_low++;
            checks++; if (VPOS !== f_vpos(t))  begin errors++; $display("FAIL fr_vpos t=%0d got %0d exp %0d", t, VPOS, f_vpos(t)); end
            checks++; if (VBLK !== f_vblk(t))  begin errors++; $display("FAIL fr_vblk t=%0d got %b exp %b", t, VBLK, f_vblk(t)); end
            checks++; if (VSYN !== f_vsyn(t, 0)) begin errors++; $display("FAIL fr_vsyn t=%0d got %b exp %b", t, VSYN, f_vsyn(t, 0)); end
            checks++; if (FRAME !== f_frame(t)) begin errors++; $display("FAIL fr_frame t=%0d got %b exp %b", t, FRAME, f_frame(t)); end
            checks++; if (HPOS !== f_hpos(t))  begin errors++; $display("FAIL fr_hpos t=%0d got %0d exp %0d", t, HPOS, f_hpos(t)); end
        end
        checks++; if (frame_cnt != 1)        begin errors++; $display("FAIL fr_frame_count got %0d exp 1", frame_cnt); end
        checks++; if (vsyn_low != 3 * c_HT)  begin errors++; $display("FAIL fr_vsyn_width got %0d exp %0d", vsyn_low, 3 * c_HT); end
    endtask

    task automatic test_offsets();
        int ho;
        int vo;
        int hsyn_low_f2 = 0;
        HOFS = 4'd3; VOFS = 4'd2;
        while (t < 3 * c_FT + 16 * c_HT) begin
            if (t == 2 * c_FT + 16 * c_HT) begin
                HOFS = 4'b1000; VOFS = 4'b1000;
            end
            tick(); t++;
            ho = (f_fr(t) == 1) ? 0 : (f_fr(t) == 2) ? 3 : -8;
            vo = (f_fr(t) == 1) ? 0 : (f_fr(t) == 2) ? 2 : -8;
            if (f_fr(t) == 2 && HSYN === 1'b0) hsyn_low_f2++;
            checks++; if (HSYN !== f_hsyn(t, ho)) begin errors++; $display("FAIL of_hsyn t=%0d got %b exp %b", t, HSYN, f_hsyn(t, ho)); end
            checks++; if (VSYN !== f_vsyn(t, vo)) begin errors++; $display("FAIL of_vsyn t=%0d got %b exp %b", t, VSYN, f_vsyn(t, vo)); end
        end
        checks++; if (hsyn_low_f2 != 32 * 31) begin errors++; $display("FAIL of_hsyn_width got %0d exp %0d", hsyn_low_f2, 32 * 31); end
        HOFS = 4'd0; VOFS = 4'd0;
    endtask

    task automatic test_ce_gating();
        logic [11:0] exp_rgb;
        logic        ce_now;
        while (t < 4 * c_FT - 3) begin
            tick(); t++;
        end
        for (int n = 0; n < 8 * 400; n++) begin
            ce_now = (n % 8 == 0);
            CE   = ce_now;
            iRGB = ce_now ? 12'hABC : 12'($urandom);
            tick();
            if (ce_now) t++;
            exp_rgb = f_de(t - 1) ? 12'hABC : 12'h000;
            checks++; if (HPOS !== f_hpos(t))  begin errors++; $display("FAIL ce_hpos t=%0d got %0d exp %0d", t, HPOS, f_hpos(t)); end
            checks++; if (VPOS !== f_vpos(t))  begin errors++; $display("FAIL ce_vpos t=%0d got %0d exp %0d", t, VPOS, f_vpos(t)); end
            checks++; if (DE !== f_de(t))      begin errors++; $display("FAIL ce_de t=%0d got %b exp %b", t, DE, f_de(t)); end
            checks++; if (oRGB !== exp_rgb)    begin errors++; $display("FAIL ce_orgb t=%0d got %h exp %h", t, oRGB, exp_rgb); end
            checks++; if (LINE !== f_line(t))  begin errors++; $display("FAIL ce_line t=%0d got %b exp %b", t, LINE, f_line(t)); end
            checks++; if (FRAME !== f_frame(t)) begin errors++; $display("FAIL ce_frame t=%0d got %b exp %b", t, FRAME, f_frame(t)); end
        end
        CE = 1'b1; iRGB = 12'hABC;
    endtask

    task automatic test_reset_mid();
        while (t < 4 * c_FT + 5 * c_HT + 100) begin
            tick(); t++;
        end
        checks++; if (HPOS !== 9'd100) begin errors++; $display("FAIL rm_pre_hpos got %0d exp 100", HPOS); end
        checks++; if (VPOS !== 9'd5)   begin errors++; $display("FAIL rm_pre_vpos got %0d exp 5", VPOS); end
        #3;
        RESET = 1'b1;
        #1;
        checks++; if (HPOS !== 9'd0)  begin errors++; $display("FAIL rm_async_hpos got %0d exp 0", HPOS); end
        checks++; if (VPOS !== 9'd0)  begin errors++; $display("FAIL rm_async_vpos got %0d exp 0", VPOS); end
        checks++; if (HBLK !== 1'b1)  begin errors++; $display("FAIL rm_async_hblk got %b exp 1", HBLK); end
        checks++; if (VBLK !== 1'b1)  begin errors++; $display("FAIL rm_async_vblk got %b exp 1", VBLK); end
        checks++; if (oRGB !== 12'h0) begin errors++; $display("FAIL rm_async_orgb got %h exp 0", oRGB); end
        checks++; if (DE !== 1'b0)    begin errors++; $display("FAIL rm_async_de got %b exp 0", DE); end
        repeat (3) tick();
        checks++; if (HPOS !== 9'd0)  begin errors++; $display("FAIL rm_hold_hpos got %0d exp 0", HPOS); end
        RESET = 1'b0;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); t++;
            checks++; if (HPOS !== f_hpos(t)) begin errors++; $display("FAIL rm_hpos t=%0d got %0d exp %0d", t, HPOS, f_hpos(t)); end
            checks++; if (VPOS !== f_vpos(t)) begin errors++; $display("FAIL rm_vpos t=%0d got %0d exp %0d", t, VPOS, f_vpos(t)); end
            checks++; if (HBLK !== 1'b1)      begin errors++; $display("FAIL rm_hblk t=%0d got %b exp 1", t, HBLK); end
            checks++; if (oRGB !== 12'h0)     begin errors++; $display("FAIL rm_orgb t=%0d got %h exp 0", t, oRGB); end
        end
    endtask

    initial begin
        test_reset();
        test_hline();
        test_frame();
        test_offsets();
        test_ce_gating();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
